// File: rtl/ad9228_pkg.sv
// Shared types for the AD9228 serial-output emulator: source modes, FSM state
// and the checkerboard words.
package ad9228_pkg;

  typedef enum logic [1:0] {
    MODE_STREAM,
    MODE_FIXED,
    MODE_RAMP,
    MODE_CHECKER
  } tx_mode_t;

  typedef enum logic {
    TX_IDLE,
    TX_RUN
  } tx_state_t;

  localparam logic [11:0] CHECKER_A = 12'hAAA;
  localparam logic [11:0] CHECKER_B = 12'h555;

endpackage

// File: rtl/ad9228_pattern_gen.sv
// Selects the next frame word from the upstream stream or a test pattern, and
// advances the ramp/checker state only when a word is actually loaded.
module ad9228_pattern_gen
  import ad9228_pkg::*;
#(
  parameter int                    DATA_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = 12'h800,
  parameter logic [DATA_WIDTH-1:0] FIXED_WORD = 12'hA5A
) (
  input  logic                  clk,
  input  logic                  rst,
  input  tx_mode_t              mode,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  underrun
);

  // 1010... for any even width; equals CHECKER_A at 12 bits, its inverse CHECKER_B.
  localparam logic [DATA_WIDTH-1:0] CHK_A = {DATA_WIDTH/2{2'b10}};

  logic [DATA_WIDTH-1:0] ramp;
  logic [DATA_WIDTH-1:0] chk_next;
  tx_mode_t              last_mode;

  always_comb begin
    word     = IDLE_WORD;
    underrun = 1'b0;
    case (mode)
      MODE_STREAM: begin
        word     = s_valid ? s_data : IDLE_WORD;
        underrun = load & ~s_valid;
      end
      MODE_FIXED:   word = FIXED_WORD;
      MODE_RAMP:    word = ramp;
      MODE_CHECKER: word = (last_mode != MODE_CHECKER) ? CHK_A : chk_next;
      default:      word = IDLE_WORD;
    endcase
  end

  // last_mode lets the checker restart at CHK_A on every entry into CHECKER.
  always_ff @(posedge clk) begin
    if (rst) begin
      ramp      <= '0;
      chk_next  <= CHK_A;
      last_mode <= MODE_STREAM;
    end else if (load) begin
      last_mode <= mode;
      if (mode == MODE_RAMP)    ramp     <= ramp + 1'b1;
      if (mode == MODE_CHECKER) chk_next <= ~word;
    end
  end

endmodule

// File: rtl/ad9228_lvds_tx_emulator.sv
// AD9228-style serialiser: one bit per clk, MSB first, with frame clock, DDR
// data clock, frame-start pulse and a saturating stream-underrun counter.
module ad9228_lvds_tx_emulator
  import ad9228_pkg::*;
#(
  parameter int                    DATA_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = 12'h800,
  parameter logic [DATA_WIDTH-1:0] FIXED_WORD = 12'hA5A,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  dout,
  output logic                  fco,
  output logic                  dco,
  output logic                  frame_start,
  output logic [CNT_WIDTH-1:0]  underrun_cnt,
  output tx_state_t             state_dbg
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] FCO_LAST = BW'(DATA_WIDTH/2 - 1);

  tx_state_t             state;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] next_word;
  logic                  underrun;
  logic                  load;
  tx_mode_t              mode_sel;

  assign mode_sel  = tx_mode_t'(mode);
  assign load      = ~rst & (((state == TX_IDLE) & enable) |
                             ((state == TX_RUN) & (bit_idx == LAST_BIT) & enable));
  assign s_ready   = load & (mode_sel == MODE_STREAM);
  assign state_dbg = state;

  ad9228_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDLE_WORD  (IDLE_WORD),
    .FIXED_WORD (FIXED_WORD)
  ) u_pattern_gen (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode_sel),
    .load     (load),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .word     (next_word),
    .underrun (underrun)
  );

  // bit_idx names the bit currently on dout; the MSB goes straight to dout at
  // load and the shift register keeps only the remaining bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TX_IDLE;
      bit_idx     <= '0;
      shreg       <= '0;
      dout        <= 1'b0;
      fco         <= 1'b0;
      dco         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load;
      if (load) begin
        state   <= TX_RUN;
        bit_idx <= '0;
        dout    <= next_word[DATA_WIDTH-1];
        shreg   <= {next_word[DATA_WIDTH-2:0], 1'b0};
        fco     <= 1'b1;
        dco     <= (state == TX_RUN) ? ~dco : 1'b0;
      end else if ((state == TX_RUN) && (bit_idx != LAST_BIT)) begin
        bit_idx <= bit_idx + 1'b1;
        dout    <= shreg[DATA_WIDTH-1];
        shreg   <= shreg << 1;
        fco     <= (bit_idx < FCO_LAST);
        dco     <= ~dco;
      end else begin
        state   <= TX_IDLE;
        bit_idx <= '0;
        dout    <= 1'b0;
        fco     <= 1'b0;
        dco     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (underrun && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

endmodule
